// File: rtl/opamp_cal_ctrl_pkg.sv
// Shared types for the op-amp offset-calibration sequencer.
package opamp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETTLE_INIT = 3'd1,
        TEST        = 3'd2,
        DECIDE      = 3'd3,
        DONE        = 3'd4
    } cal_state_t;

    // Midscale trim code: only the MSB set.
    function automatic logic [31:0] trim_midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/opamp_cal_ctrl_if.sv
// Control/status bundle between the pad-side logic and the calibration sequencer.
interface opamp_cal_ctrl_if #(
    parameter int TRIM_W = 6
);
    logic              amp_req;
    logic              cal_start;
    logic              cmp_in;
    logic              trim_wr;
    logic [TRIM_W-1:0] trim_wdata;
    logic              amp_en;
    logic              in_short;
    logic [TRIM_W-1:0] trim_code;
    logic              cal_busy;
    logic              cal_done;
    logic              chop_clk;

    modport master (
        output amp_req, cal_start, cmp_in, trim_wr, trim_wdata,
        input  amp_en, in_short, trim_code, cal_busy, cal_done, chop_clk
    );

    modport slave (
        input  amp_req, cal_start, cmp_in, trim_wr, trim_wdata,
        output amp_en, in_short, trim_code, cal_busy, cal_done, chop_clk
    );
endinterface

// File: rtl/opamp_cal_ctrl_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
module opamp_cmp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/opamp_cal_ctrl.sv
// SAR offset-calibration sequencer for the op-amp trim DAC.
// Optional chopper clock divider built when OPAMP_CHOP_EN is defined.
//
// state       | meaning
// IDLE        | amp follows amp_req, manual trim loads accepted
// SETTLE_INIT | inputs shorted, trim = 0, wait for amplifier to settle
// TEST        | trial bit k set, wait for comparator to settle
// DECIDE      | keep or clear bit k from synchronized comparator
// DONE        | one-cycle cal_done, back to IDLE
module opamp_cal_ctrl
    import opamp_ctrl_pkg::*;
#(
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 16,
    parameter int CHOP_DIV   = 8
) (
    input logic             clk,
    input logic             rst,
    opamp_cal_ctrl_if.slave bus
);
    localparam int                KW        = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam logic [KW-1:0]     K_TOP     = KW'(TRIM_W - 1);
    localparam logic [7:0]        SETTLE_LD = 8'(SETTLE_CYC - 1);
    localparam logic [TRIM_W-1:0] TRIM_MID  = TRIM_W'(trim_midscale(TRIM_W));

    cal_state_t        state_q;
    logic [TRIM_W-1:0] trim_q;
    logic [KW-1:0]     k_q;
    logic [7:0]        cnt_q;
    logic              amp_en_q;
    logic              in_short_q;
    logic              busy_q;
    logic              done_q;
    logic              cmp_s;

    opamp_cmp_sync u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.cmp_in),
        .q_o (cmp_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            trim_q     <= TRIM_MID;
            k_q        <= K_TOP;
            cnt_q      <= '0;
            amp_en_q   <= 1'b0;
            in_short_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    amp_en_q   <= bus.amp_req;
                    in_short_q <= 1'b0;
                    busy_q     <= 1'b0;
                    // A start in the same cycle as a manual write wins.
                    if (bus.cal_start) begin
                        state_q    <= SETTLE_INIT;
                        trim_q     <= '0;
                        k_q        <= K_TOP;
                        cnt_q      <= SETTLE_LD;
                        amp_en_q   <= 1'b1;
                        in_short_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (bus.trim_wr) begin
                        trim_q <= bus.trim_wdata;
                    end
                end
                SETTLE_INIT: begin
                    if (cnt_q == 8'd0) begin
                        state_q     <= TEST;
                        trim_q[k_q] <= 1'b1;
                        cnt_q       <= SETTLE_LD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                TEST: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= DECIDE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                DECIDE: begin
                    if (cmp_s) begin
                        trim_q[k_q] <= 1'b0;
                    end
                    if (k_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q                  <= TEST;
                        k_q                      <= k_q - KW'(1);
                        trim_q[k_q - KW'(1)]     <= 1'b1;
                        cnt_q                    <= SETTLE_LD;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    amp_en_q   <= bus.amp_req;
                    in_short_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef OPAMP_CHOP_EN
    localparam logic [7:0] CHOP_LD = 8'(CHOP_DIV - 1);

    logic [7:0] div_q;
    logic       chop_q;

    // Chopper runs only while the amplifier is on and not calibrating.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= CHOP_LD;
            chop_q <= 1'b0;
        end else if (amp_en_q && !busy_q) begin
            if (div_q == 8'd0) begin
                div_q  <= CHOP_LD;
                chop_q <= ~chop_q;
            end else begin
                div_q <= div_q - 8'd1;
            end
        end else begin
            div_q  <= CHOP_LD;
            chop_q <= 1'b0;
        end
    end

    assign bus.chop_clk = chop_q;
`else
    logic unused_chop_div;
    assign unused_chop_div = ^CHOP_DIV;
    assign bus.chop_clk    = 1'b0;
`endif

    assign bus.amp_en    = amp_en_q;
    assign bus.in_short  = in_short_q;
    assign bus.trim_code = trim_q;
    assign bus.cal_busy  = busy_q;
    assign bus.cal_done  = done_q;
endmodule

// File: tb/tb_opamp_cal_ctrl.sv
// Directed bench for opamp_cal_ctrl with a behavioural comparator model.
module tb_opamp_cal_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;
    int   total = 0;
    int   bad = 0;

    opamp_cal_ctrl_if #(.TRIM_W(6)) bus ();

    opamp_cal_ctrl #(
        .TRIM_W     (6),
        .SETTLE_CYC (16),
        .CHOP_DIV   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Comparator: 0 = offset model (trips above 37), 1 = stuck high, 2 = stuck low.
    always_comb begin
        case (mode)
            0:       bus.cmp_in = (bus.trim_code > 6'd37);
            1:       bus.cmp_in = 1'b1;
            default: bus.cmp_in = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Start at one posedge (edge N); sample i is the negedge i cycles later.
    task automatic run_cal(input int inject, input logic wr_with_start,
                           output int lat, output int busy_cnt, output int short_bad,
                           output int chop_bad, output int first_trim);
        lat = -1; busy_cnt = 0; short_bad = 0; chop_bad = 0; first_trim = -1;
        bus.cal_start  = 1'b1;
        bus.trim_wr    = wr_with_start;
        bus.trim_wdata = 6'd12;
        @(negedge clk);
        for (int i = 1; i <= 300; i++) begin
            bus.cal_start = (i == inject);
            bus.trim_wr   = (i == inject);
            if (i == 1) first_trim = int'(bus.trim_code);
            if (bus.cal_busy) begin
                busy_cnt++;
                if (!bus.in_short) short_bad++;
                if (bus.chop_clk) chop_bad++;
            end
            if (bus.cal_done && lat < 0) lat = i;
            if (lat >= 0 && !bus.cal_busy) break;
            @(negedge clk);
        end
        bus.cal_start = 1'b0;
        bus.trim_wr   = 1'b0;
    endtask

    int lat, busy_cnt, short_bad, chop_bad, first_trim;
    int done_cnt, rise_a, rise_b, highs;

    initial begin
        bus.amp_req    = 1'b1;
        bus.cal_start  = 1'b0;
        bus.trim_wr    = 1'b0;
        bus.trim_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_trim",  int'(bus.trim_code), 32);
        chk("rst_amp",   int'(bus.amp_en),    0);
        chk("rst_busy",  int'(bus.cal_busy),  0);
        chk("rst_chop",  int'(bus.chop_clk),  0);
        rst = 1'b0;

        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cal_done) done_cnt++;
        end
        chk("idle_trim",  int'(bus.trim_code), 32);
        chk("idle_amp",   int'(bus.amp_en),    1);
        chk("idle_short", int'(bus.in_short),  0);
        chk("idle_done",  done_cnt,            0);

        bus.trim_wr    = 1'b1;
        bus.trim_wdata = 6'd12;
        @(negedge clk);
        bus.trim_wr = 1'b0;
        chk("wr_load", int'(bus.trim_code), 12);

        mode = 0;
        run_cal(0, 1'b0, lat, busy_cnt, short_bad, chop_bad, first_trim);
        chk("cal37_lat",   lat,                 119);
        chk("cal37_busy",  busy_cnt,            119);
        chk("cal37_short", short_bad,           0);
        chk("cal37_chop",  chop_bad,            0);
        chk("cal37_code",  int'(bus.trim_code), 37);
        chk("cal37_idle",  int'(bus.in_short),  0);

        mode = 1;
        run_cal(0, 1'b0, lat, busy_cnt, short_bad, chop_bad, first_trim);
        chk("stuck1_lat",  lat,                 119);
        chk("stuck1_code", int'(bus.trim_code), 0);

        mode = 2;
        run_cal(0, 1'b0, lat, busy_cnt, short_bad, chop_bad, first_trim);
        chk("stuck0_code", int'(bus.trim_code), 63);

        mode = 0;
        run_cal(40, 1'b0, lat, busy_cnt, short_bad, chop_bad, first_trim);
        chk("midcal_lat",  lat,                 119);
        chk("midcal_code", int'(bus.trim_code), 37);

        run_cal(0, 1'b1, lat, busy_cnt, short_bad, chop_bad, first_trim);
        chk("both_first", first_trim,          0);
        chk("both_lat",   lat,                 119);
        chk("both_code",  int'(bus.trim_code), 37);

        rise_a = -1; rise_b = -1; highs = 0;
        for (int i = 1; i <= 80; i++) begin
            logic prev;
            prev = bus.chop_clk;
            @(negedge clk);
            if (bus.chop_clk) highs++;
            if (bus.chop_clk && !prev) begin
                if (rise_a < 0) rise_a = i;
                else if (rise_b < 0) rise_b = i;
            end
        end
`ifdef OPAMP_CHOP_EN
        chk("chop_period", rise_b - rise_a, 16);
`else
        chk("chop_off", highs, 0);
`endif

        bus.cal_start = 1'b1;
        @(negedge clk);
        bus.cal_start = 1'b0;
        repeat (49) @(negedge clk);
        chk("pre_rst_busy", int'(bus.cal_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_trim",  int'(bus.trim_code), 32);
        chk("mrst_busy",  int'(bus.cal_busy),  0);
        chk("mrst_short", int'(bus.in_short),  0);
        chk("mrst_done",  int'(bus.cal_done),  0);
        done_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.cal_done) done_cnt++;
        end
        chk("mrst_nodone", done_cnt,           0);
        chk("mrst_amp",    int'(bus.amp_en),   1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/opamp_cal_ctrl.md
# opamp_cal_ctrl

Digital offset-calibration sequencer for the on-die sky130 op-amp. It sits in the user-project digital wrapper between the pad-side control bits and the analog macro. It drives the amplifier enable, an input-short switch and a 6-bit offset-trim DAC code. It runs a successive-approximation (SAR) search on the trim code using the op-amp's output comparator, and holds the result until the next calibration or a manual trim write.

## Interface

Parameters:
- TRIM_W, 6, width of the trim DAC code.
- SETTLE_CYC, 16, analog settle cycles per SAR step; legal range 3 to 255.
- CHOP_DIV, 8, half-period of the chopper clock in `clk` cycles; used only when OPAMP_CHOP_EN is defined.

Ports:
- clk  in  1  single design clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- amp_req  in  1  request amplifier on while IDLE.
- cal_start  in  1  start a calibration; sampled in IDLE only.
- cmp_in  in  1  comparator output from the analog macro; asynchronous.
- trim_wr  in  1  manual trim load strobe.
- trim_wdata  in  TRIM_W  manual trim value.
- amp_en  out  1  amplifier bias enable.
- in_short  out  1  shorts the amplifier inputs during calibration.
- trim_code  out  TRIM_W  trim DAC code.
- cal_busy  out  1  calibration in progress.
- cal_done  out  1  one-cycle pulse when calibration completes.
- chop_clk  out  1  chopper switch clock.

## Operation

Reset values:
- trim_code = midscale (MSB set, all other bits 0; 6'b100000 at default width).
- amp_en, in_short, cal_busy, cal_done, chop_clk = 0.
- FSM in IDLE.

Input handling:
- cmp_in passes through a 2-flop synchronizer before use. The synchronizer flops also reset to 0.

FSM states:
- IDLE:
  - amp_en = amp_req; in_short = 0.
  - cal_start = 1 moves to SETTLE_INIT, clears trim_code to 0 and sets bit index k = TRIM_W-1.
  - Otherwise, trim_wr = 1 loads trim_wdata into trim_code.
  - If cal_start and trim_wr are both high in the same cycle, cal_start wins and trim_wr is dropped.
- SETTLE_INIT:
  - amp_en = 1, in_short = 1, cal_busy = 1.
  - Stays SETTLE_CYC cycles, then goes to TEST.
- TEST:
  - Sets trim_code[k] = 1 on entry.
  - Waits SETTLE_CYC cycles, then goes to DECIDE.
- DECIDE (1 cycle):
  - If the synchronized comparator value is 1, clear trim_code[k].
  - If k = 0, go to DONE; otherwise decrement k and go to TEST.
- DONE (1 cycle):
  - cal_done = 1.
  - in_short drops and cal_busy drops on the transition to IDLE.

Rules outside IDLE:
- cal_start and trim_wr are ignored in every state other than IDLE.
- trim_code changes only on TEST entry, in DECIDE, on a load in IDLE, and on reset.

Comparator boundary cases:
- Comparator stuck at 1 gives final code 0.
- Comparator stuck at 0 gives final code all-ones.

## Timing

- trim_wr in IDLE appears on trim_code on the next cycle.
- A cal_start sampled at edge N produces cal_busy = 1 from cycle N+1.
- cal_done pulses SETTLE_CYC + TRIM_W·(SETTLE_CYC+1) + 1 cycles after edge N. This is 119 cycles at default parameters.
- cal_busy is high for exactly that same span, and cal_done is asserted in the last cycle of it.
- Every SAR step spans at least 3 cycles, so a comparator change caused by the new trim code is visible through the 2-cycle synchronizer before DECIDE samples it.
- rst asserted in any state, including mid-calibration: all outputs take their reset values on the next edge, with no cal_done pulse.
- All outputs are registered.

## Configuration

OPAMP_CHOP_EN defined:
- chop_clk toggles every CHOP_DIV cycles while amp_en = 1 and cal_busy = 0.
- Leaving that condition resets the divider and forces chop_clk = 0.
- chop_clk first toggles CHOP_DIV cycles after the condition becomes true.

OPAMP_CHOP_EN undefined:
- chop_clk is tied to 0 and no divider logic exists.

## Structure

Package opamp_ctrl_pkg holds:
- The state enum (IDLE, SETTLE_INIT, TEST, DECIDE, DONE).
- A function returning the midscale trim constant for a given TRIM_W.

Sub-module:
- opamp_cmp_sync is the 2-flop synchronizer for cmp_in; it has a synchronous reset.

Everything else (FSM, settle counter, bit index, trim register, chopper divider) lives in opamp_cal_ctrl.

## Test plan

1. Reset, then idle with amp_req = 1 -> trim_code = 6'b100000, amp_en = 1, in_short = 0, cal_done never pulses.
2. Model with comparator output = (trim_code > 6'd37), then pulse cal_start -> final trim_code = 6'd37, cal_done pulses exactly 119 cycles after the start edge, in_short = 1 throughout busy.
3. Comparator stuck at 1 -> trim_code = 0; comparator stuck at 0 -> trim_code = 6'd63.
4. trim_wr with 6'd12 in IDLE -> trim_code = 12 next cycle. trim_wr and cal_start asserted mid-calibration -> both ignored, result unchanged. trim_wr and cal_start in the same IDLE cycle -> calibration starts and the 12 load is dropped.
5. rst asserted 50 cycles into a calibration -> next cycle trim_code = 6'b100000, cal_busy = 0, in_short = 0, no cal_done pulse.
6. With OPAMP_CHOP_EN and amp_req = 1 -> chop_clk period is 16 cycles, held at 0 during calibration; without the macro -> chop_clk stays 0.
